tb_mem_bridge: RTL and testbench
================================

Name: tb_mem_bridge

Overview:
Testbench-side bridge between the core's valid/ready data-memory port and the single-port word RAM model: 1-cycle registered read, word write, byte address with word index = addr>>2.
Converts one core request into RAM accesses: word read, full-word write, or read-modify-write for byte-enabled stores.
Returns one buffered response per request.
Sits directly upstream of the RAM model in every data-memory bench.

Parameters:
MEM_SIZE, 4096, RAM depth in 32-bit words; must match the RAM model.
ADDR_W, $clog2(MEM_SIZE*4), RAM byte-address width (derived, not overridden).

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  core request valid
req_ready  out  1  bridge can accept; high only in IDLE
req_we  in  1  1 = write, 0 = read
req_be  in  4  byte enables for writes, bit i = byte i (little-endian); ignored on reads
req_addr  in  32  byte address
req_wdata  in  32  write data, byte i in bits [8i+7:8i]
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  access error (out of range, or misaligned with feature on)
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM byte address, bits [1:0] always 0
ram_din  out  32  RAM write data
ram_dout  in  32  RAM read data, valid one cycle after address presented

Behaviour:
- Reset values: state IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0; ram_we=0, ram_addr=0, ram_din=0; req_ready=1 from the first cycle after reset.
- Decode from state register: ram_we, req_ready and rsp_valid are decoded from the state register, so rst forces ram_we=0 from the next edge.
- Reset mid-operation: aborts the request with no response. A partial RMW with its write not yet issued leaves the RAM unmodified.
- States: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RESP.
- Capture: on accept (req_valid && req_ready, cycle T) register we, be, addr, wdata; rsp_err=0.
- Routing from IDLE:
  - address >= MEM_SIZE*4 -> RESP with rsp_err=1, no RAM access.
  - write with be=0 -> RESP with no RAM access.
  - read -> RD.
  - write with be=4'hF -> WR.
  - other writes -> RMW_RD.
- RD (T+1): ram_addr = {addr_q[ADDR_W-1:2],2'b00}, ram_we=0 -> RD_WAIT.
- RD_WAIT (T+2): rsp_rdata <= ram_dout -> RESP. rsp_valid first high at T+3.
- WR (T+1): ram_we=1, ram_din=wdata_q -> RESP. rsp_valid at T+2.
- RMW_RD (T+1): read as in RD -> RMW_MERGE.
- RMW_MERGE (T+2): ram_we=1, ram_din byte i = be_q[i] ? wdata_q byte i : ram_dout byte i (combinational from ram_dout) -> RESP. rsp_valid at T+3.
- RESP: rsp_valid=1; rsp_rdata/rsp_err stable until rsp_valid && rsp_ready, then IDLE with rsp_valid=0 and rsp_rdata/rsp_err cleared.
- Throughput: no request is accepted while a response is pending. Best throughput is one read per 4 cycles with rsp_ready held high.
- Outside active states: ram_addr holds its last value; ram_din=0 whenever ram_we=0.
- Without MEM_BRIDGE_MISALIGN_CHK_EN: addr[1:0] is ignored and the access proceeds on the containing word.

Optional Feature:
MEM_BRIDGE_MISALIGN_CHK_EN
- Defined: in IDLE, any request with req_addr[1:0]!=0 goes directly to RESP with rsp_err=1, no RAM access, rsp_rdata=0. The out-of-range check still applies, and error has priority over be=0.
- Undefined: no alignment check; behaviour as in Behaviour.

Test Plan:
- Read: RAM word 5 preloaded 32'hDEADBEEF; read addr 32'h14 accepted at T -> rsp_valid at T+3, rsp_rdata=32'hDEADBEEF, rsp_err=0, ram_we never high.
- Full write: write addr 32'h20, be=4'hF, wdata=32'h12345678 -> ram_we high at T+1 only, ram_din=32'h12345678, rsp_valid at T+2; a following read of 32'h20 returns 32'h12345678.
- Byte-enabled write: word 8 = 32'hAABBCCDD; write addr 32'h20, be=4'b0101, wdata=32'h11223344 -> one write at T+2 with ram_din=32'hAA22CC44; rsp_valid at T+3.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout; handshake on the 6th cycle -> req_ready=1 next cycle.
- Error and reset: read of addr MEM_SIZE*4 (32'h4000) -> rsp_err=1 at T+1, no RAM access. Then rst asserted during RMW_RD -> no RAM write, rsp_valid=0 and req_ready=1 after release, target word unchanged.
- Misalignment: read addr 32'h22 -> with MEM_BRIDGE_MISALIGN_CHK_EN, rsp_err=1 at T+1 and no RAM access; without it, data of word 8 at T+3.

Source files
------------

// File: rtl/tb_mem_bridge.sv
// tb_mem_bridge
//   Bridge between a core valid/ready data-memory port and a single-port word
//   RAM model (1-cycle registered read). Each accepted request becomes a word
//   read, a full-word write, or a read-modify-write for partial byte enables.
//   Exactly one buffered response is returned per request.
//
// Optional feature macro: MEM_BRIDGE_MISALIGN_CHK_EN
//   Defined  : requests with addr[1:0] != 0 are answered with rsp_err_o=1 and
//              no RAM access.
//   Undefined: addr[1:0] is ignored; the containing word is accessed.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*_i/req_ready_o core request channel (valid/ready)
//   rsp_*_o/rsp_ready_i core response channel (valid/ready)
//   ram_we_o, ram_addr_o, ram_din_o, ram_dout_i   RAM model port
//
// States
//   state     | meaning
//   IDLE      | ready to accept a request
//   RD        | word address presented for a read
//   RD_WAIT   | RAM data arriving, captured into the response register
//   WR        | full-word write issued
//   RMW_RD    | word address presented for the read half of a byte write
//   RMW_MERGE | merged word written back
//   RESP      | response held until accepted
module tb_mem_bridge #(
  parameter  int MEM_SIZE = 4096,
  localparam int ADDR_W   = $clog2(MEM_SIZE * 4)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [3:0]        req_be_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  input  logic [31:0]       ram_dout_i
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE * 4);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD        = 3'd1,
    RD_WAIT   = 3'd2,
    WR        = 3'd3,
    RMW_RD    = 3'd4,
    RMW_MERGE = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-3:0]   widx_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic                acc_err;
  logic                accept;
  logic [31:0]         merged;

  assign accept = (state_q == IDLE) && req_valid_i;

`ifdef MEM_BRIDGE_MISALIGN_CHK_EN
  assign acc_err = (req_addr_i >= MEM_BYTES) || (req_addr_i[1:0] != 2'b00);
`else
  assign acc_err = (req_addr_i >= MEM_BYTES);
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; error wins over an empty byte mask
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (acc_err)                          state_d = RESP;
          else if (req_we_i && req_be_i == 4'h0) state_d = RESP;
          else if (!req_we_i)                    state_d = RD;
          else if (req_be_i == 4'hF)             state_d = WR;
          else                                   state_d = RMW_RD;
        end
      end
      RD:        state_d = RD_WAIT;
      RD_WAIT:   state_d = RESP;
      WR:        state_d = RESP;
      RMW_RD:    state_d = RMW_MERGE;
      RMW_MERGE: state_d = RESP;
      RESP:      if (rsp_ready_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Byte merge straight from the RAM read data in RMW_MERGE
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_dout_i[8*i +: 8];
    end
  end

  // Output decode from the state register
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    ram_we_o    = 1'b0;
    ram_din_o   = '0;
    unique case (state_q)
      IDLE:      req_ready_o = 1'b1;
      WR: begin
        ram_we_o  = 1'b1;
        ram_din_o = wdata_q;
      end
      RMW_MERGE: begin
        ram_we_o  = 1'b1;
        ram_din_o = merged;
      end
      RESP:      rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request capture and response buffer. The word index only moves for
  // requests that reach the RAM, so ram_addr_o holds its last value otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      be_q        <= '0;
      wdata_q     <= '0;
      widx_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        be_q        <= req_be_i;
        wdata_q     <= req_wdata_i;
        rsp_rdata_q <= '0;
        rsp_err_q   <= acc_err;
        if (state_d == RD || state_d == WR || state_d == RMW_RD) begin
          widx_q <= req_addr_i[ADDR_W-1:2];
        end
      end
      if (state_q == RD_WAIT) begin
        rsp_rdata_q <= ram_dout_i;
      end
      if (state_q == RESP && rsp_ready_i) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign ram_addr_o  = {widx_q, 2'b00};
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_tb_mem_bridge.sv
// Self-checking bench for tb_mem_bridge: a small registered-read RAM model,
// a vector table for single requests, a response scoreboard, and hand-written
// sequences for backpressure and reset during a read-modify-write.
module tb_tb_mem_bridge;

  localparam int MEM_SIZE = 4096;
  localparam int ADDR_W   = $clog2(MEM_SIZE * 4);

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [3:0]        req_be;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  tb_mem_bridge #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_be_i    (req_be),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_din_o   (ram_din),
    .ram_dout_i  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a bench-side preload port
  logic [31:0]        mem [0:MEM_SIZE-1];
  logic               pre_we;
  logic [ADDR_W-3:0]  pre_idx;
  logic [31:0]        pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (ram_we) mem[ram_addr[ADDR_W-1:2]] <= ram_din;
    ram_dout <= mem[ram_addr[ADDR_W-1:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int wr_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  // Scoreboard: compare each handshaked response against the queued expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected response: rdata %h err %0b, none queued", rsp_rdata, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // RAM write data must be zero whenever no write is issued
  always @(negedge clk) begin
    if (ram_we) wr_total++;
    else chk("ram_din idle", ram_din, 32'h0);
  end

  task automatic preload(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = idx[ADDR_W-3:0];
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Drive one request, queue its expected response, and watch the RAM port
  // until rsp_valid rises. lat counts cycles after the accept cycle.
  task automatic issue_req(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           output int lat, output int wr_cnt, output int wr_lat,
                           output logic [31:0] wr_din, output logic [31:0] wr_addr);
    int   n;
    bit   got;
    rsp_t e;
    lat = 0; wr_cnt = 0; wr_lat = 0; wr_din = '0; wr_addr = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept timeout: req_ready %0b, required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ram_we) begin
        wr_cnt++;
        wr_lat  = lat;
        wr_din  = ram_din;
        wr_addr = 32'(ram_addr);
      end
      if (rsp_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL response timeout: rsp_valid %0b after %0d cycles, required 1", rsp_valid, lat);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          exp_wr_lat;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  initial begin : main
    int          lat, wr_cnt, wr_lat, n, wr_before;
    logic [31:0] wr_din, wr_addr;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 4'h0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    pre_we    = 1'b0;
    pre_idx   = '0;
    pre_data  = '0;

    preload(5,    32'hDEADBEEF);
    preload(8,    32'hAABBCCDD);
    preload(4095, 32'hCAFEF00D);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset req_ready", 32'(req_ready), 32'h1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_err",   32'(rsp_err),   32'h0);
    chk("reset rsp_rdata", rsp_rdata,      32'h0);
    chk("reset ram_we",    32'(ram_we),    32'h0);
    chk("reset ram_addr",  32'(ram_addr),  32'h0);
    chk("reset ram_din",   ram_din,        32'h0);

    //            we    be      addr          wdata         rdata         err   lat wr wl din
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0014, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'hAABBCCDD, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'h5, 32'h0000_0020, 32'h11223344, 32'h0,        1'b0, 3, 1, 2, 32'hAA22CC44});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'hAA22CC44, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0020, 32'h12345678, 32'h0,        1'b0, 2, 1, 1, 32'h12345678});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0020, 32'h0,        32'h12345678, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_4000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_4000, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0020, 32'hFFFFFFFF, 32'h0,        1'b0, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_3FFC, 32'h0,        32'hCAFEF00D, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'h8, 32'h0000_3FFC, 32'h99000000, 32'h0,        1'b0, 3, 1, 2, 32'h99FEF00D});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_3FFC, 32'h0,        32'h99FEF00D, 1'b0, 3, 0, 0, 32'h0});
`ifdef MEM_BRIDGE_MISALIGN_CHK_EN
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0022, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0021, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0});
`else
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0022, 32'h0,        32'h12345678, 1'b0, 3, 0, 0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0021, 32'h0,        32'h0,        1'b0, 1, 0, 0, 32'h0});
`endif

    foreach (vecs[i]) begin
      issue_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err, lat, wr_cnt, wr_lat, wr_din, wr_addr);
      n = 0;
      while (rsp_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d ram writes", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0) begin
        chk($sformatf("v%0d write cycle", i), 32'(wr_lat), 32'(vecs[i].exp_wr_lat));
        chk($sformatf("v%0d ram_din", i), wr_din, vecs[i].exp_din);
        chk($sformatf("v%0d ram_addr", i), wr_addr, {vecs[i].addr[31:2], 2'b00});
      end
      chk($sformatf("v%0d rsp_valid cleared", i), 32'(rsp_valid), 32'h0);
    end

    // Backpressure: response held 5 cycles, handshake in the 6th
    rsp_ready = 1'b0;
    issue_req(1'b0, 4'h0, 32'h14, 32'h0, 32'hDEADBEEF, 1'b0, lat, wr_cnt, wr_lat, wr_din, wr_addr);
    chk("bp latency", 32'(lat), 32'h3);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp rsp_valid c%0d", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp rsp_rdata c%0d", k), rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp rsp_err c%0d", k), 32'(rsp_err), 32'h0);
      chk($sformatf("bp req_ready c%0d", k), 32'(req_ready), 32'h0);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp rsp_valid c5", 32'(rsp_valid), 32'h1);
    chk("bp req_ready c5", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("bp req_ready after", 32'(req_ready), 32'h1);
    chk("bp rsp_valid after", 32'(rsp_valid), 32'h0);
    chk("bp rsp_rdata cleared", rsp_rdata, 32'h0);

    // Reset while the read half of a byte write is in flight
    @(negedge clk);
    wr_before = wr_total;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_be    = 4'b0011;
    req_addr  = 32'h20;
    req_wdata = 32'h55556666;
    chk("rmw-rst req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rmw-rst ram_we in RMW_RD", 32'(ram_we), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rmw-rst rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rmw-rst req_ready", 32'(req_ready), 32'h1);
    end
    chk("rmw-rst ram writes", 32'(wr_total), 32'(wr_before));
    chk("rmw-rst word 8", mem[8], 32'h12345678);

    // Bridge still works after the abort
    issue_req(1'b0, 4'h0, 32'h20, 32'h0, 32'h12345678, 1'b0, lat, wr_cnt, wr_lat, wr_din, wr_addr);
    chk("post-rst read latency", 32'(lat), 32'h3);
    repeat (2) @(negedge clk);

    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, test incomplete");
    $fatal(1, "watchdog");
  end

endmodule
